// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
//   - Operation select codes driven on mdu.op_i.
//   - FSM state codes used inside mdu.
//   - Small decode helpers for the operation select.
package mdu_pkg;

  // Operation select
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  // FSM states
  localparam logic [1:0] MDU_ST_IDLE    = 2'd0;
  localparam logic [1:0] MDU_ST_RUN     = 2'd1;
  localparam logic [1:0] MDU_ST_DIVZERO = 2'd2;
  localparam logic [1:0] MDU_ST_DONE    = 2'd3;

  function automatic logic mdu_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic mdu_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring radix-2 divide iteration.
//   i_partial  [WIDTH:0]   previous remainder shifted left with the next dividend bit
//   i_divisor  [WIDTH-1:0] divisor magnitude
//   o_rem      [WIDTH-1:0] next partial remainder
//   o_qbit                 quotient bit produced by this iteration
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   i_partial,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH-1:0] w_diff;

  // Modular difference is exact whenever the subtraction is taken (result < divisor).
  assign w_diff = i_partial[WIDTH-1:0] - i_divisor;
  assign o_qbit = (i_partial >= {1'b0, i_divisor});
  assign o_rem  = o_qbit ? w_diff : i_partial[WIDTH-1:0];

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit for a pipelined CPU.
//   clk, rst (async, active-low)
//   start_i, op_i[1:0], opdata1_i, opdata2_i : operation request
//   annul_i     : kill the operation in flight
//   stallreq_o  : hold the pipeline while busy
//   ready_o     : one-cycle result-valid pulse; hi_o/lo_o hold until the next result
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle combinational multiplier
// for MULT/MULTU; division is always iterative.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]         r_state, w_state_next;
  logic [1:0]         r_op;
  logic [CntW-1:0]    r_cnt;
  logic               r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_start_ok, w_signed, w_load;
  logic [WIDTH-1:0]   w_abs1, w_abs2, w_rem, w_res_hi, w_res_lo;
  logic               w_qbit;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_step, w_prod;

  assign w_start_ok = start_i & ~annul_i;
  assign w_signed   = mdu_is_signed(op_i);
  // Magnitudes; the most-negative value maps onto itself, read as unsigned.
  assign w_abs1 = (w_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (w_signed && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // r_acc holds {upper/remainder, multiplier/dividend}; r_b is multiplicand/divisor.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_partial ({r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]}),
    .i_divisor (r_b),
    .o_rem     (w_rem),
    .o_qbit    (w_qbit)
  );

  assign w_div_next = {w_rem, r_acc[WIDTH-2:0], w_qbit};
  assign w_step     = mdu_is_div(r_op) ? w_div_next : w_mul_next;

  // Result with sign correction, computed as it is loaded into hi/lo.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_prod   = '0;
    if (r_state == MDU_ST_DIVZERO) begin
      // Undoing the magnitude step restores the original dividend.
      w_res_hi = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_res_lo = '1;
    end else if (mdu_is_div(r_op)) begin
      w_res_hi = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
      w_res_lo = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    end else begin
      w_prod   = r_neg_q ? -w_step : w_step;
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
`ifdef MDU_FAST_MUL_EN
    if (r_state == MDU_ST_IDLE) begin
      w_prod = {{WIDTH{1'b0}}, w_abs1} * {{WIDTH{1'b0}}, w_abs2};
      if (w_signed && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1])) begin
        w_prod = -w_prod;
      end
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      MDU_ST_IDLE: begin
        if (w_start_ok) begin
          if (mdu_is_div(op_i) && (opdata2_i == '0)) begin
            w_state_next = MDU_ST_DIVZERO;
`ifdef MDU_FAST_MUL_EN
          end else if (!mdu_is_div(op_i)) begin
            w_state_next = MDU_ST_DONE;
            w_load       = 1'b1;
`endif
          end else begin
            w_state_next = MDU_ST_RUN;
          end
        end
      end
      MDU_ST_RUN: begin
        if (r_cnt == LastCnt) begin
          w_state_next = MDU_ST_DONE;
          w_load       = 1'b1;
        end
      end
      MDU_ST_DIVZERO: begin
        w_state_next = MDU_ST_DONE;
        w_load       = 1'b1;
      end
      MDU_ST_DONE: w_state_next = MDU_ST_IDLE;
      default:     w_state_next = MDU_ST_IDLE;
    endcase
    // Annul overrides everything, including a result about to land.
    if (annul_i) begin
      w_state_next = MDU_ST_IDLE;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MDU_ST_IDLE;
      r_cnt   <= '0;
      r_op    <= MDU_MULT;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= ((r_state == MDU_ST_RUN) && (w_state_next == MDU_ST_RUN)) ?
                 r_cnt + 1'b1 : '0;
      if ((r_state == MDU_ST_IDLE) && w_start_ok) begin
        r_op    <= op_i;
        r_b     <= w_abs2;
        r_acc   <= {{WIDTH{1'b0}}, w_abs1};
        r_neg_q <= w_signed & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
        r_neg_r <= w_signed & opdata1_i[WIDTH-1];
      end else if (r_state == MDU_ST_RUN) begin
        r_acc <= w_step;
      end
      if (w_load) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign ready_o    = (r_state == MDU_ST_DONE);
  // rst gates the start term so the stall is low while reset is held.
  assign stallreq_o = ((r_state == MDU_ST_IDLE) & w_start_ok & rst) |
                      (r_state == MDU_ST_RUN) | (r_state == MDU_ST_DIVZERO);
  assign hi_o       = r_hi;
  assign lo_o       = r_lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic        clk, rst, start_i, annul_i, stallreq_o, ready_o;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i, hi_o, lo_o;
  int          n_cmp, n_fail;
  logic [31:0] last_hi, last_lo;
  int          rdy;

  mdu #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit poke_done);
    int lat, stl;
    @(negedge clk);
    op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    #1 check({name, " start stall"}, stallreq_o, 1);
    @(negedge clk);
    start_i = 1'b0; lat = 1; stl = 0;
    while (!ready_o && lat < 100) begin
      if (stallreq_o) stl++;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy stall cycles"}, stl, exp_lat - 1);
    check({name, " ready"}, ready_o, 1);
    check({name, " done stall"}, stallreq_o, 0);
    check({name, " hi"}, hi_o, ehi);
    check({name, " lo"}, lo_o, elo);
    // Optionally request a new op during DONE; it must be ignored.
    if (poke_done) start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check({name, " ready pulse width"}, ready_o, 0);
    check({name, " idle stall"}, stallreq_o, 0);
    check({name, " hi hold"}, hi_o, ehi);
    check({name, " lo hold"}, lo_o, elo);
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; last_hi = '0; last_lo = '0;
    rst = 1'b0; start_i = 1'b1; annul_i = 1'b0; op_i = MDU_DIVU;
    opdata1_i = 32'd1; opdata2_i = 32'd1;
    repeat (3) @(negedge clk);
    check("reset hi", hi_o, 0);
    check("reset lo", lo_o, 0);
    check("reset ready", ready_o, 0);
    check("reset stall", stallreq_o, 0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op("DIVU 100/7", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    run_op("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("MULT -1*2", MDU_MULT, 32'hFFFF_FFFF, 32'd2, MulLat, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 1'b0);
    run_op("MULTU ffffffff*2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MulLat, 32'd1,
           32'hFFFF_FFFE, 1'b0);
    run_op("DIV 5/0", MDU_DIV, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV -7/0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op("DIV 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("DIV minneg/1", MDU_DIV, 32'h8000_0000, 32'd1, 33, 32'd0, 32'h8000_0000, 1'b0);
    run_op("DIV minneg/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,
           32'h8000_0000, 1'b0);
    run_op("MULT minneg^2", MDU_MULT, 32'h8000_0000, 32'h8000_0000, MulLat, 32'h4000_0000,
           32'd0, 1'b0);
    run_op("MULT -3*5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, MulLat, 32'hFFFF_FFFF,
           32'hFFFF_FFF1, 1'b1);
    run_op("DIVU max/16", MDU_DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'hF, 32'h0FFF_FFFF, 1'b0);

    // Annul in the 10th RUN cycle.
    @(negedge clk);
    op_i = MDU_DIVU; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("annul run stall", stallreq_o, 1);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    check("annul idle stall", stallreq_o, 0);
    check("annul ready", ready_o, 0);
    check("annul hi hold", hi_o, last_hi);
    check("annul lo hold", lo_o, last_lo);
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("annul no ready", rdy, 0);
    run_op("DIVU 9/3", MDU_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3, 1'b0);

    // Simultaneous start and annul: annul wins.
    @(negedge clk);
    op_i = MDU_DIVU; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1; annul_i = 1'b1;
    #1 check("start+annul stall", stallreq_o, 0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1 check("start+annul idle", stallreq_o, 0);
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("start+annul no ready", rdy, 0);
    check("start+annul lo hold", lo_o, last_lo);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    op_i = MDU_DIVU; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun reset hi", hi_o, 0);
    check("midrun reset lo", lo_o, 0);
    check("midrun reset ready", ready_o, 0);
    check("midrun reset stall", stallreq_o, 0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("post reset no ready", rdy, 0);
    check("post reset stall", stallreq_o, 0);
    run_op("DIVU 100/7 again", MDU_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
